// File: rtl/reduce_ingress.sv
// Ingress stage ahead of the reduction unit: tags each flit with its binomial-tree
// children count and queues {children, flit} in a show-ahead FIFO. Build option: INVALID_DROP_EN.
module reduce_ingress #(
  parameter logic [2:0] rank_z       = 3'b0,
  parameter logic [2:0] rank_y       = 3'b0,
  parameter logic [2:0] rank_x       = 3'b0,
  parameter int         lg_numprocs  = 4,
  parameter int         PayloadWidth = 64,
  parameter int         lg_depth     = 4,
  localparam int        FlitWidth    = PayloadWidth + 50,
  localparam int        CW           = lg_numprocs
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FlitWidth-1:0]    in_flit,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FlitWidth+CW-1:0] packetA,
  input  logic                    rd_en,
  output logic                    buf_empty,
  output logic                    buf_full,
  output logic [12:0]             fifo_counter
);

  localparam int EW    = FlitWidth + CW;
  localparam int PW    = lg_depth + 1;
  localparam int DEPTH = 1 << lg_depth;

  localparam logic [8:0]    ME_FULL = {rank_z, rank_y, rank_x};
  localparam logic [CW-1:0] ME      = ME_FULL[CW-1:0];

  logic [CW-1:0] root;
  logic [CW-1:0] rel;
  logic [CW-1:0] tz;
  logic [CW-1:0] children;
  logic          is_red;
  logic          accept;

  logic          s1_valid;
  logic [EW-1:0] s1_data;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] rd_next;
  logic          push;
  logic          pop;
  logic          last;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  assign root   = in_flit[PayloadWidth+30 +: CW];
  assign rel    = ME - root;
  assign is_red = (in_flit[PayloadWidth+3 -: 2] == 2'b11) && in_flit[FlitWidth-1];

  // Trailing-zero count; the root (rel == 0) owns all CW subtrees.
  always_comb begin
    tz = CW'(CW);
    for (int i = CW - 1; i >= 0; i--) begin
      if (rel[i]) tz = CW'(i);
    end
    children = is_red ? tz : '0;
  end

  assign in_ready = !s1_valid || !buf_full;

`ifdef INVALID_DROP_EN
  assign accept = in_valid && in_ready && in_flit[FlitWidth-1];
`else
  assign accept = in_valid && in_ready;
`endif

  // buf_full is the pre-pop status, so a full FIFO never pushes in the cycle it pops.
  assign push = s1_valid && !buf_full;
  assign pop  = rd_en && !buf_empty;

  assign count        = wr_ptr - rd_ptr;
  assign rd_next      = rd_ptr + PW'(1);
  assign last         = (count == PW'(1));
  assign buf_empty    = (wr_ptr == rd_ptr);
  assign buf_full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign fifo_counter = 13'(count);
  assign packetA      = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (push) begin
        s1_valid <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) s1_data <= {children, in_flit};
  end

  // Head register: loaded directly when the pushed entry becomes the head,
  // otherwise prefetched from the array on pop; held when the queue runs dry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[lg_depth-1:0]] <= s1_data;
    if (push && (buf_empty || (pop && last))) begin
      head <= s1_data;
    end else if (pop && !last) begin
      head <= mem[rd_next[lg_depth-1:0]];
    end
  end

endmodule
